hazard_ctrl_unit: RTL and testbench

- Control-side counterpart of the fetch/decode stages; it produces the freeze, flush, branch_taken and branch_addr signals that IF_stage and IF_stage_reg consume.
- Tracks in-flight destination registers in an internal EXE/MEM scoreboard and compares them against the ID-stage source registers.
- Asserts freeze on a RAW hazard and flush when EXE resolves a taken branch.
- Also keeps a saturating stall-cycle performance counter.

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/hazard_match.sv | 22 ++
 rtl/hazard_ctrl_unit.sv | 87 ++++++++
 tb/tb_hazard_ctrl_unit.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types for the hazard control unit: register-index width,
// the EXE/MEM scoreboard entry and the empty-slot constant.
package pipe_pkg;

  // 16 ARM registers.
  localparam int REG_AW = 4;

  // PC register index; compared like any other index, kept for readability.
  localparam logic [REG_AW-1:0] PC_IDX = 4'd15;

  // One in-flight producer tracked by the scoreboard.
  typedef struct packed {
    logic              valid;
    logic              wb_en;
    logic              mem_read;
    logic [REG_AW-1:0] dest;
  } sb_entry_t;

  // Empty slot inserted on freeze or flush.
  localparam sb_entry_t BUBBLE = '{valid: 1'b0, wb_en: 1'b0, mem_read: 1'b0, dest: '0};

endpackage : pipe_pkg

// File: rtl/hazard_match.sv
// Compares one scoreboard slot against the ID-stage source registers and
// reports whether the ID instruction reads the slot's pending result.
module hazard_match
  import pipe_pkg::*;
(
  input  sb_entry_t         slot,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_two_src,
  output logic              match
);

  logic src1_hit;
  logic src2_hit;

  // Source 2 only counts when the instruction actually reads it.
  assign src1_hit = (id_src1 == slot.dest);
  assign src2_hit = id_two_src && (id_src2 == slot.dest);
  assign match    = slot.valid && slot.wb_en && id_valid && (src1_hit || src2_hit);

endmodule : hazard_match

// File: rtl/hazard_ctrl_unit.sv
// Hazard control for the IF/ID stages: tracks EXE/MEM producers, freezes on a
// RAW hazard, flushes on a taken branch and counts stall cycles (saturating).
module hazard_ctrl_unit
  import pipe_pkg::*;
#(
  parameter bit FORWARD_EN = 1'b0,
  parameter int CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [pipe_pkg::REG_AW-1:0] id_src1,
  input  logic [pipe_pkg::REG_AW-1:0] id_src2,
  input  logic                      id_two_src,
  input  logic                      id_wb_en,
  input  logic                      id_mem_read,
  input  logic [pipe_pkg::REG_AW-1:0] id_dest,
  input  logic                      exe_branch_taken,
  input  logic [31:0]               exe_branch_addr,
  output logic                      freeze,
  output logic                      flush,
  output logic                      branch_taken,
  output logic [31:0]               branch_addr,
  output logic [CNT_W-1:0]          stall_count
);

  // WB is not tracked: the register file writes on the falling edge, so a
  // WB-stage result is already visible to ID.
  sb_entry_t exe_q;
  sb_entry_t mem_q;
  logic      match_exe;
  logic      match_mem;
  logic      raw_hazard;

  hazard_match u_match_exe (
    .slot       (exe_q),
    .id_valid   (id_valid),
    .id_src1    (id_src1),
    .id_src2    (id_src2),
    .id_two_src (id_two_src),
    .match      (match_exe)
  );

  hazard_match u_match_mem (
    .slot       (mem_q),
    .id_valid   (id_valid),
    .id_src1    (id_src1),
    .id_src2    (id_src2),
    .id_two_src (id_two_src),
    .match      (match_mem)
  );

  // With forwarding only a load in EXE cannot be bypassed in time.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    raw_hazard = 1'b0;
    if (FORWARD_EN) raw_hazard = match_exe && exe_q.mem_read;
    else            raw_hazard = match_exe || match_mem;
  end

  // Flush wins over freeze: the stalled ID instruction is squashed anyway.
  assign freeze       = raw_hazard && !exe_branch_taken;
  assign flush        = exe_branch_taken;
  assign branch_taken = exe_branch_taken;
  assign branch_addr  = exe_branch_taken ? exe_branch_addr : 32'd0;

  // Advance the scoreboard; a frozen or flushed ID instruction enters as a bubble.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      exe_q <= BUBBLE;
      mem_q <= BUBBLE;
    end else begin
      mem_q <= exe_q;
      if (freeze || flush) exe_q <= BUBBLE;
      else                 exe_q <= '{valid: id_valid, wb_en: id_wb_en,
                                      mem_read: id_mem_read, dest: id_dest};
    end
  end

  // Count freeze cycles, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                stall_count <= '0;
    else if (freeze && (stall_count != '1)) stall_count <= stall_count + 1'b1;
  end

endmodule : hazard_ctrl_unit

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit. Three instances share the stimulus:
// d0 (no forwarding), d1 (forwarding), d2 (no forwarding, 4-bit counter).
module tb_hazard_ctrl_unit;
  import pipe_pkg::*;

  logic              clk;
  logic              rst;
  logic              id_valid;
  logic [REG_AW-1:0] id_src1;
  logic [REG_AW-1:0] id_src2;
  logic              id_two_src;
  logic              id_wb_en;
  logic              id_mem_read;
  logic [REG_AW-1:0] id_dest;
  logic              exe_branch_taken;
  logic [31:0]       exe_branch_addr;

  logic        freeze0, flush0, bt0;
  logic [31:0] ba0;
  logic [15:0] cnt0;
  logic        freeze1, flush1, bt1;
  logic [31:0] ba1;
  logic [15:0] cnt1;
  logic        freeze2, flush2, bt2;
  logic [31:0] ba2;
  logic [3:0]  cnt2;

  int n_compared   = 0;
  int n_mismatched = 0;

  hazard_ctrl_unit #(.FORWARD_EN(1'b0), .CNT_W(16)) d0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
    .id_dest(id_dest), .exe_branch_taken(exe_branch_taken),
    .exe_branch_addr(exe_branch_addr), .freeze(freeze0), .flush(flush0),
    .branch_taken(bt0), .branch_addr(ba0), .stall_count(cnt0)
  );

  hazard_ctrl_unit #(.FORWARD_EN(1'b1), .CNT_W(16)) d1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
    .id_dest(id_dest), .exe_branch_taken(exe_branch_taken),
    .exe_branch_addr(exe_branch_addr), .freeze(freeze1), .flush(flush1),
    .branch_taken(bt1), .branch_addr(ba1), .stall_count(cnt1)
  );

  hazard_ctrl_unit #(.FORWARD_EN(1'b0), .CNT_W(4)) d2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
    .id_dest(id_dest), .exe_branch_taken(exe_branch_taken),
    .exe_branch_addr(exe_branch_addr), .freeze(freeze2), .flush(flush2),
    .branch_taken(bt2), .branch_addr(ba2), .stall_count(cnt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change 1 time unit after the rising edge; outputs are sampled after that.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                       input logic two, input logic wb, input logic mr,
                       input logic [3:0] d);
    id_valid    = v;
    id_src1     = s1;
    id_src2     = s2;
    id_two_src  = two;
    id_wb_en    = wb;
    id_mem_read = mr;
    id_dest     = d;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic do_reset();
    exe_branch_taken = 1'b0;
    exe_branch_addr  = 32'd0;
    idle();
    rst = 1'b0;
    step();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    exe_branch_taken = 1'b0;
    exe_branch_addr  = 32'd0;
    for (int i = 0; i < 3; i++) begin
      drive($urandom_range(0, 1), 4'($urandom), 4'($urandom), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 1), 4'($urandom));
      n_compared++;
      if (freeze0 !== 1'b0 || flush0 !== 1'b0 || cnt0 !== 16'd0 || freeze1 !== 1'b0) begin
        n_mismatched++;
        $display("FAIL reset_hold cyc%0d: freeze0=%b flush0=%b cnt0=%0d freeze1=%b, want 0 0 0 0",
                 i, freeze0, flush0, cnt0, freeze1);
      end
      step();
    end
    idle();
    n_compared++;
    if (bt0 !== 1'b0 || ba0 !== 32'd0) begin
      n_mismatched++;
      $display("FAIL reset_branch: branch_taken=%b branch_addr=%h, want 0 0", bt0, ba0);
    end
    rst = 1'b1;
    #1;
    // Slots empty after release: an instruction reading r0 (bubble dest) must not stall.
    drive(1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd2);
    n_compared++;
    if (freeze0 !== 1'b0 || freeze2 !== 1'b0 || cnt2 !== 4'd0) begin
      n_mismatched++;
      $display("FAIL reset_first_instr: freeze0=%b freeze2=%b cnt2=%0d, want 0 0 0",
               freeze0, freeze2, cnt2);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1'b1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0, 4'd1);   // ADD r1,r2,r3
    step();
    drive(1'b1, 4'd1, 4'd3, 1'b1, 1'b1, 1'b0, 4'd2);   // SUB r2,r1,r3
    for (int i = 0; i < 3; i++) begin
      n_compared++;
      if (freeze0 !== (i < 2)) begin
        n_mismatched++;
        $display("FAIL b2b_freeze cyc%0d: freeze=%b, want %b", i, freeze0, (i < 2));
      end
      if (i < 2) step();
    end
    n_compared++;
    if (cnt0 !== 16'd2) begin
      n_mismatched++;
      $display("FAIL b2b_count: stall_count=%0d, want 2", cnt0);
    end
    n_compared++;
    if (freeze1 !== 1'b0 || cnt1 !== 16'd0) begin
      n_mismatched++;
      $display("FAIL b2b_forwarded: freeze=%b cnt=%0d, want 0 0", freeze1, cnt1);
    end
  endtask

  task automatic test_two_ahead();
    do_reset();
    drive(1'b1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0, 4'd1);   // ADD r1
    step();
    drive(1'b1, 4'd7, 4'd8, 1'b1, 1'b1, 1'b0, 4'd9);   // independent
    step();
    drive(1'b1, 4'd1, 4'd3, 1'b1, 1'b1, 1'b0, 4'd2);   // reads r1, producer in MEM
    n_compared++;
    if (freeze0 !== 1'b1) begin
      n_mismatched++;
      $display("FAIL two_ahead_freeze: freeze=%b, want 1", freeze0);
    end
    step();
    n_compared++;
    if (freeze0 !== 1'b0 || cnt0 !== 16'd1) begin
      n_mismatched++;
      $display("FAIL two_ahead_release: freeze=%b cnt=%0d, want 0 1", freeze0, cnt0);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd4);   // LDR r4
    step();
    drive(1'b1, 4'd4, 4'd6, 1'b1, 1'b1, 1'b0, 4'd5);   // ADD r5,r4,r6
    n_compared++;
    if (freeze1 !== 1'b1) begin
      n_mismatched++;
      $display("FAIL load_use_freeze: freeze=%b, want 1", freeze1);
    end
    step();
    n_compared++;
    if (freeze1 !== 1'b0 || cnt1 !== 16'd1) begin
      n_mismatched++;
      $display("FAIL load_use_release: freeze=%b cnt=%0d, want 0 1", freeze1, cnt1);
    end
    do_reset();
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd4);   // ADD r4 (not a load)
    step();
    drive(1'b1, 4'd4, 4'd6, 1'b1, 1'b1, 1'b0, 4'd5);
    for (int i = 0; i < 2; i++) begin
      n_compared++;
      if (freeze1 !== 1'b0) begin
        n_mismatched++;
        $display("FAIL alu_use_forwarded cyc%0d: freeze=%b, want 0", i, freeze1);
      end
      step();
    end
  endtask

  task automatic test_branch_hazard();
    do_reset();
    drive(1'b1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0, 4'd1);   // ADD r1
    exe_branch_addr = 32'h0000_1234;
    #1;
    n_compared++;
    if (bt0 !== 1'b0 || ba0 !== 32'd0 || flush0 !== 1'b0) begin
      n_mismatched++;
      $display("FAIL branch_not_taken: bt=%b addr=%h flush=%b, want 0 0 0", bt0, ba0, flush0);
    end
    step();
    drive(1'b1, 4'd1, 4'd3, 1'b1, 1'b1, 1'b0, 4'd2);   // hazard on r1
    exe_branch_taken = 1'b1;
    exe_branch_addr  = 32'h0000_0040;
    #1;
    n_compared++;
    if (flush0 !== 1'b1 || bt0 !== 1'b1 || ba0 !== 32'h40 || freeze0 !== 1'b0) begin
      n_mismatched++;
      $display("FAIL branch_hazard: flush=%b bt=%b addr=%h freeze=%b, want 1 1 00000040 0",
               flush0, bt0, ba0, freeze0);
    end
    step();
    exe_branch_taken = 1'b0;
    idle();
    n_compared++;
    if (cnt0 !== 16'd0 || freeze0 !== 1'b0) begin
      n_mismatched++;
      $display("FAIL branch_count: cnt=%0d freeze=%b, want 0 0", cnt0, freeze0);
    end
  endtask

  task automatic test_two_src();
    do_reset();
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd3);   // producer r3
    step();
    drive(1'b1, 4'd7, 4'd3, 1'b0, 1'b1, 1'b0, 4'd8);   // src2=r3 not read
    n_compared++;
    if (freeze0 !== 1'b0) begin
      n_mismatched++;
      $display("FAIL two_src_off: freeze=%b, want 0", freeze0);
    end
    drive(1'b1, 4'd7, 4'd3, 1'b1, 1'b1, 1'b0, 4'd8);   // src2=r3 read
    n_compared++;
    if (freeze0 !== 1'b1) begin
      n_mismatched++;
      $display("FAIL two_src_on: freeze=%b, want 1", freeze0);
    end
    do_reset();
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, PC_IDX); // writes r15
    step();
    drive(1'b1, PC_IDX, 4'd0, 1'b0, 1'b1, 1'b0, 4'd1);
    n_compared++;
    if (freeze0 !== 1'b1) begin
      n_mismatched++;
      $display("FAIL pc_src: freeze=%b, want 1", freeze0);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    // r1 = r1 op r2 held in ID: enters, then stalls 2 cycles on itself, repeat.
    drive(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 1'b0, 4'd1);
    for (int k = 0; k < 30; k++) begin
      n_compared++;
      if (freeze0 !== ((k % 3) != 0)) begin
        n_mismatched++;
        $display("FAIL self_dep_freeze k%0d: freeze=%b, want %b", k, freeze0, ((k % 3) != 0));
      end
      step();
    end
    n_compared++;
    if (cnt2 !== 4'd15 || cnt0 !== 16'd20) begin
      n_mismatched++;
      $display("FAIL saturate: cnt4=%0d cnt16=%0d, want 15 20", cnt2, cnt0);
    end
    step();                                            // k=31: stalled
    n_compared++;
    if (freeze2 !== 1'b1) begin
      n_mismatched++;
      $display("FAIL pre_reset_stall: freeze=%b, want 1", freeze2);
    end
    #2;
    rst = 1'b0;
    #1;
    n_compared++;
    if (freeze2 !== 1'b0 || cnt2 !== 4'd0 || cnt0 !== 16'd0) begin
      n_mismatched++;
      $display("FAIL async_reset: freeze=%b cnt4=%0d cnt16=%0d, want 0 0 0", freeze2, cnt2, cnt0);
    end
    step();
    rst = 1'b1;
    #1;
    n_compared++;
    if (freeze2 !== 1'b0) begin
      n_mismatched++;
      $display("FAIL post_reset_first: freeze=%b, want 0", freeze2);
    end
  endtask

  initial begin
    rst              = 1'b0;
    exe_branch_taken = 1'b0;
    exe_branch_addr  = 32'd0;
    id_valid         = 1'b0;
    id_src1          = '0;
    id_src2          = '0;
    id_two_src       = 1'b0;
    id_wb_en         = 1'b0;
    id_mem_read      = 1'b0;
    id_dest          = '0;
    #1;
    test_reset();
    test_back_to_back();
    test_two_ahead();
    test_load_use();
    test_branch_hazard();
    test_two_src();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule : tb_hazard_ctrl_unit
